// File: rtl/mem_lsu_if.sv
// mem_lsu_if -- bundle of the load/store unit's pipeline-side and
// data-memory-side signals.
//   Pipeline side : in_valid, mem_op, addr, wdata -> stall, out_valid,
//                   out_data, misalign, bus_err
//   Memory side   : dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata ->
//                   dmem_ready, dmem_rdata
// Modport slave is taken by the LSU; master is the surrounding pipeline and
// memory (the environment that drives the LSU inputs).
interface mem_lsu_if;
    logic        in_valid;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_data;
    logic        misalign;
    logic        bus_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport slave (
        input  in_valid, mem_op, addr, wdata, dmem_ready, dmem_rdata,
        output stall, out_valid, out_data, misalign, bus_err,
               dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata
    );

    modport master (
        output in_valid, mem_op, addr, wdata, dmem_ready, dmem_rdata,
        input  stall, out_valid, out_data, misalign, bus_err,
               dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu -- memory-stage load/store unit.
// Accepts one access from execute, checks alignment, issues a single
// word-aligned request on the data-memory port, waits (bounded by TIMEOUT_CYC
// request cycles) for dmem_ready, then pulses out_valid for one cycle with the
// extended load data or a misalign / bus_err fault.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_lsu_if.slave (pipeline request/response and data-memory port)
module mem_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic      clk,
    input  logic      rst,
    mem_lsu_if.slave  bus
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] result_q;
    logic        mis_q;
    logic        err_q;
    logic [7:0]  cnt_q;
    logic        rst_d;     // high in the first cycle after reset
    logic        accept;
    logic        live;
    logic        store_q;

    function automatic logic is_valid_op(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_LH, OP_LHU, OP_SH: return a[0];
            OP_LW, OP_SW:         return a != 2'b00;
            default:              return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [3:0] op, input logic [1:0] a,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{a, 3'b000} +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'd0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            OP_LW:   return rdata;
            default: return 32'd0;     // stores complete with zero data
        endcase
    endfunction

    function automatic logic [3:0] store_strobe(input logic [3:0] op, input logic [1:0] a);
        case (op)
            OP_SB:   return 4'b0001 << a;
            OP_SH:   return a[1] ? 4'b1100 : 4'b0011;
            OP_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   return {4{d[7:0]}};
            OP_SH:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Acceptance is blocked during reset and the cycle after it so every
    // output is quiet through that window, even with a valid op presented.
    assign live    = !rst;
    assign accept  = live && !rst_d && (state != REQ) && bus.in_valid && is_valid_op(bus.mem_op);
    assign store_q = (op_q >= OP_SB) && (op_q <= OP_SW);

    // stall is combinational: the accepting cycle holds upstream, as does
    // every REQ cycle. A DONE cycle with no new access releases it.
    assign bus.stall      = accept || (live && state == REQ);
    assign bus.out_valid  = live && (state == DONE);
    assign bus.out_data   = bus.out_valid ? result_q : 32'd0;
    assign bus.misalign   = bus.out_valid && mis_q;
    assign bus.bus_err    = bus.out_valid && err_q;
    assign bus.dmem_req   = live && (state == REQ);
    assign bus.dmem_we    = bus.dmem_req && store_q;
    assign bus.dmem_addr  = bus.dmem_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus.dmem_wstrb = bus.dmem_req ? store_strobe(op_q, addr_q[1:0]) : 4'd0;
    assign bus.dmem_wdata = bus.dmem_we ? store_data(op_q, wdata_q) : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            result_q <= 32'd0;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
            rst_d    <= 1'b1;
        end else begin
            rst_d <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q     <= bus.mem_op;
                        addr_q   <= bus.addr;
                        wdata_q  <= bus.wdata;
                        cnt_q    <= 8'd0;
                        result_q <= 32'd0;
                        err_q    <= 1'b0;
                        if (is_misaligned(bus.mem_op, bus.addr[1:0])) begin
                            mis_q <= 1'b1;
                            state <= DONE;
                        end else begin
                            mis_q <= 1'b0;
                            state <= REQ;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (bus.dmem_ready) begin
                        result_q <= load_extend(op_q, addr_q[1:0], bus.dmem_rdata);
                        state    <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        // TIMEOUT_CYC request cycles spent with no ready
                        err_q <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_lsu_if bus();

    mem_lsu #(.TIMEOUT_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;      // REQ cycle in which ready is given, 0 = never
        int          exp_nreq;
        logic [31:0] exp_daddr;
        logic        exp_we;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_out;
        logic        exp_mis;
        logic        exp_err;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".stall"},      32'(bus.stall),      32'd0);
        chk({tag, ".out_valid"},  32'(bus.out_valid),  32'd0);
        chk({tag, ".out_data"},   bus.out_data,        32'd0);
        chk({tag, ".misalign"},   32'(bus.misalign),   32'd0);
        chk({tag, ".bus_err"},    32'(bus.bus_err),    32'd0);
        chk({tag, ".dmem_req"},   32'(bus.dmem_req),   32'd0);
        chk({tag, ".dmem_we"},    32'(bus.dmem_we),    32'd0);
        chk({tag, ".dmem_addr"},  bus.dmem_addr,       32'd0);
        chk({tag, ".dmem_wstrb"}, 32'(bus.dmem_wstrb), 32'd0);
        chk({tag, ".dmem_wdata"}, bus.dmem_wdata,      32'd0);
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_vec(input int idx, input vec_t v);
        int  nreq;
        int  lat;
        bit  seen;
        string tag;
        tag = $sformatf("v%0d", idx);
        n_vec++;
        bus.in_valid   = 1'b1;
        bus.mem_op     = v.op;
        bus.addr       = v.addr;
        bus.wdata      = v.wdata;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = v.rdata;
        @(negedge clk);
        chk({tag, ".accept_stall"}, 32'(bus.stall), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mem_op   = 4'd0;
        nreq = 0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            lat++;
            bus.dmem_ready = bus.dmem_req && (v.delay != 0) && (nreq + 1 == v.delay);
            @(negedge clk);
            if (bus.dmem_req) begin
                nreq++;
                chk({tag, ".dmem_addr"},  bus.dmem_addr,       v.exp_daddr);
                chk({tag, ".dmem_we"},    32'(bus.dmem_we),    32'(v.exp_we));
                chk({tag, ".dmem_wstrb"}, 32'(bus.dmem_wstrb), 32'(v.exp_wstrb));
                if (v.exp_we) chk({tag, ".dmem_wdata"}, bus.dmem_wdata, v.exp_wdata);
                chk({tag, ".req_stall"}, 32'(bus.stall), 32'd1);
            end
            if (bus.out_valid) begin
                seen = 1'b1;
                chk({tag, ".out_data"},   bus.out_data,      v.exp_out);
                chk({tag, ".misalign"},   32'(bus.misalign), 32'(v.exp_mis));
                chk({tag, ".bus_err"},    32'(bus.bus_err),  32'(v.exp_err));
                chk({tag, ".done_stall"}, 32'(bus.stall),    32'd0);
            end
            @(posedge clk); #1;
        end
        bus.dmem_ready = 1'b0;
        chk({tag, ".done_seen"}, 32'(seen), 32'd1);
        chk({tag, ".req_cycles"}, 32'(nreq), 32'(v.exp_nreq));
        chk({tag, ".latency"}, 32'(lat), 32'(v.exp_nreq + 1));
        @(negedge clk);
        chk({tag, ".pulse_end"}, 32'(bus.out_valid), 32'd0);
        chk({tag, ".idle_req"},  32'(bus.dmem_req),  32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           op     addr        wdata         rdata         dly nreq daddr       we wstrb  wdata_exp     out            mis err
        vt[0]  = '{4'd1, 32'h103, 32'h0,        32'h80FFFF7F, 2, 2, 32'h100, 1'b0, 4'h0, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0};
        vt[1]  = '{4'd7, 32'h022, 32'h1234ABCD, 32'h0,        1, 1, 32'h020, 1'b1, 4'hC, 32'hABCDABCD, 32'h0,        1'b0, 1'b0};
        vt[2]  = '{4'd5, 32'h041, 32'h0,        32'h0,        1, 0, 32'h0,   1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0};
        vt[3]  = '{4'd5, 32'h200, 32'h0,        32'h0,        0, 4, 32'h200, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1};
        vt[4]  = '{4'd2, 32'h101, 32'h0,        32'h80FFFF7F, 1, 1, 32'h100, 1'b0, 4'h0, 32'h0,        32'h000000FF, 1'b0, 1'b0};
        vt[5]  = '{4'd3, 32'h102, 32'h0,        32'h80017FFF, 3, 3, 32'h100, 1'b0, 4'h0, 32'h0,        32'hFFFF8001, 1'b0, 1'b0};
        vt[6]  = '{4'd4, 32'h100, 32'h0,        32'h8001F00D, 1, 1, 32'h100, 1'b0, 4'h0, 32'h0,        32'h0000F00D, 1'b0, 1'b0};
        vt[7]  = '{4'd5, 32'h03C, 32'h0,        32'hDEADBEEF, 2, 2, 32'h03C, 1'b0, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
        vt[8]  = '{4'd6, 32'h011, 32'h000000A5, 32'h0,        1, 1, 32'h010, 1'b1, 4'h2, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
        vt[9]  = '{4'd8, 32'h080, 32'hCAFEF00D, 32'h0,        2, 2, 32'h080, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
        vt[10] = '{4'd7, 32'h023, 32'h00000001, 32'h0,        1, 0, 32'h0,   1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0};
        vt[11] = '{4'd1, 32'h100, 32'h0,        32'h0000007F, 1, 1, 32'h100, 1'b0, 4'h0, 32'h0,        32'h0000007F, 1'b0, 1'b0};
        vt[12] = '{4'd6, 32'h013, 32'hFFFFFF3C, 32'h0,        1, 1, 32'h010, 1'b1, 4'h8, 32'h3C3C3C3C, 32'h0,        1'b0, 1'b0};

        // Reset with a valid op held on the inputs: outputs stay quiet in
        // reset and in the first cycle after it.
        bus.in_valid   = 1'b1;
        bus.mem_op     = 4'd5;
        bus.addr       = 32'h0;
        bus.wdata      = 32'h0;
        bus.dmem_ready = 1'b0;
        bus.dmem_rdata = 32'h0;
        rst = 1'b1;
        n_vec++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk_quiet("in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_reset");
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk_quiet("idle");
        @(posedge clk); #1;

        // Op none (0 and an unused code) is ignored.
        n_vec++;
        bus.in_valid = 1'b1;
        bus.mem_op   = 4'd0;
        @(negedge clk);
        chk("none0.stall", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        bus.mem_op = 4'd12;
        @(negedge clk);
        chk("none12.stall", 32'(bus.stall), 32'd0);
        chk("none0.out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mem_op   = 4'd0;
        @(negedge clk);
        chk("none12.out_valid", 32'(bus.out_valid), 32'd0);
        chk("none12.dmem_req", 32'(bus.dmem_req), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run_vec(i, vt[i]);

        // Back-to-back: LW presented in the DONE cycle of an SB.
        n_vec++;
        bus.in_valid   = 1'b1;
        bus.mem_op     = 4'd6;
        bus.addr       = 32'h4;
        bus.wdata      = 32'h11;
        bus.dmem_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.mem_op     = 4'd0;
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        chk("b2b.sb_req", 32'(bus.dmem_req), 32'd1);
        chk("b2b.sb_wstrb", 32'(bus.dmem_wstrb), 32'h1);
        @(posedge clk); #1;
        bus.dmem_ready = 1'b0;
        bus.in_valid   = 1'b1;
        bus.mem_op     = 4'd5;
        bus.addr       = 32'h8;
        bus.dmem_rdata = 32'h5A5A1234;
        @(negedge clk);
        chk("b2b.sb_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b.sb_data", bus.out_data, 32'd0);
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        bus.mem_op     = 4'd0;
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        chk("b2b.lw_req_direct", 32'(bus.dmem_req), 32'd1);
        chk("b2b.lw_addr", bus.dmem_addr, 32'h8);
        chk("b2b.no_valid_in_req", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        chk("b2b.lw_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b.lw_data", bus.out_data, 32'h5A5A1234);
        @(posedge clk); #1;

        // Reset during the second REQ cycle aborts the access.
        n_vec++;
        bus.in_valid   = 1'b1;
        bus.mem_op     = 4'd5;
        bus.addr       = 32'h0;
        bus.dmem_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.mem_op   = 4'd0;
        @(negedge clk);
        chk("rstreq.req1", 32'(bus.dmem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rstreq.req_%0d", k), 32'(bus.dmem_req), 32'd0);
            chk($sformatf("rstreq.valid_%0d", k), 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1;
        end
        run_vec(13, '{4'd2, 32'h0, 32'h0, 32'h000000FF, 1, 1, 32'h0, 1'b0, 4'h0, 32'h0,
                       32'h000000FF, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, giving the maximum number of REQ cycles waited for dmem_ready before a bus error is raised (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1, the execute-stage result is valid this cycle.
REQ-005 SHALL have port mem_op, input, 4, the access type: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; codes 9-15 are treated as none.
REQ-006 SHALL have port addr, input, 32, the byte address (the ALU result from execute).
REQ-007 SHALL have port wdata, input, 32, the store data (rs2 value).
REQ-008 SHALL have port stall, output, 1, holds execute/decode/fetch stages.
REQ-009 SHALL have port out_valid, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port out_data, output, 32, extended load data; 0 for stores and errors.
REQ-011 SHALL have port misalign, output, 1, qualifies out_valid: alignment fault.
REQ-012 SHALL have port bus_err, output, 1, qualifies out_valid: timeout fault.
REQ-013 SHALL have dmem_req, dmem_we, dmem_addr[31:0], dmem_wstrb[3:0] and dmem_wdata[31:0] as outputs, and dmem_ready and dmem_rdata[31:0] as inputs, forming the data-memory port.

Function
REQ-014 SHALL implement states IDLE, REQ and DONE.
REQ-015 SHALL accept an access in IDLE or DONE when in_valid=1 and mem_op is a valid op (1..8).
  - An accepted access latches mem_op, addr, wdata and addr[1:0].
REQ-016 SHALL define an access as misaligned when:
  - a halfword op has addr[0]=1, or
  - a word op has addr[1:0]!=0.
REQ-017 SHALL handle an aligned accepted access as follows:
  - the next state is REQ;
  - stall=1 combinationally in the accepting cycle.
REQ-018 SHALL handle a misaligned accepted access as follows:
  - the next state is DONE with misalign=1;
  - no dmem_req is ever raised for it;
  - stall=1 in the accepting cycle.
REQ-019 SHALL handle REQ as follows:
  - dmem_req=1;
  - dmem_addr={addr[31:2],2'b00};
  - dmem_we=1 for stores and 0 for loads;
  - stall=1;
  - all dmem outputs stay stable until dmem_ready=1 is sampled.
REQ-020 SHALL move from REQ to DONE in the cycle dmem_ready=1 is sampled, capturing dmem_rdata.
REQ-021 SHALL count REQ cycles; when the count reaches TIMEOUT_CYC without dmem_ready, the next state is DONE with bus_err=1, and dmem_req drops.
REQ-022 SHALL, in DONE, drive out_valid=1 and stall=0 for exactly one cycle.
  - Next state is REQ or DONE if a new access is accepted in that cycle, otherwise IDLE.
REQ-023 SHALL select the load lane by the latched addr[1:0]:
  - LB/LBU use byte addr[1:0], sign- or zero-extended;
  - LH/LHU use halfword addr[1], sign- or zero-extended;
  - LW uses the whole word.
REQ-024 SHALL form store strobes as follows:
  - SB: dmem_wstrb=4'b0001<<addr[1:0], dmem_wdata=byte replicated x4;
  - SH: dmem_wstrb=4'b0011 or 4'b1100 by addr[1], dmem_wdata=halfword replicated x2;
  - SW: dmem_wstrb=4'b1111;
  - loads: dmem_wstrb=0.
REQ-025 SHALL take no action for in_valid with op none:
  - stall=0;
  - out_valid stays 0 (except a DONE pulse for a prior access).
REQ-026 SHALL ignore in_valid while in REQ, because stall holds upstream.
REQ-027 SHALL drive out_data=0 whenever misalign=1 or bus_err=1.
  - misalign and bus_err are 0 whenever out_valid=0.

Reset
REQ-028 SHALL, when rst=1 at a clock edge in any state, set the state to IDLE and clear the timeout counter and all latched fields.
REQ-029 SHALL drive these outputs to 0 while in reset and in the first cycle after it: stall, out_valid, out_data, misalign, bus_err, dmem_req, dmem_we, dmem_addr, dmem_wstrb and dmem_wdata.
REQ-030 SHALL, on reset during REQ, drop dmem_req in the next cycle and never produce out_valid for the aborted access.

Verification
REQ-031 SHALL cover LB: addr=0x103, dmem_rdata=0x80FF_FF7F, ready after 2 REQ cycles -> dmem_addr=0x100, stall high for 3 cycles, out_valid with out_data=0xFFFF_FF80.
REQ-032 SHALL cover SH: addr=0x22, wdata=0x1234_ABCD, ready immediately -> dmem_we=1, dmem_wstrb=4'b1100, dmem_wdata=0xABCD_ABCD, out_data=0.
REQ-033 SHALL cover misaligned LW: addr=0x41 -> no dmem_req, out_valid=1 with misalign=1 one cycle after acceptance, out_data=0.
REQ-034 SHALL cover timeout: TIMEOUT_CYC=4, dmem_ready tied 0 -> dmem_req high for exactly 4 cycles, then out_valid=1 with bus_err=1.
REQ-035 SHALL cover back-to-back: LW in DONE cycle of SB -> second access enters REQ directly, no IDLE cycle, both out_valid pulses seen.
REQ-036 SHALL cover reset in REQ: rst=1 during second REQ cycle -> dmem_req=0 next cycle, no out_valid, subsequent LBU addr=0x0 with rdata=0xFF returns 0x0000_00FF.
